demux_buf: RTL and testbench
============================

# demux_buf

Buffered 1-to-2 demultiplexer for 16-bit words: the steering counterpart of the datapath 2:1 select mux. It accepts one word per cycle on a valid/ready input, routes it by a select bit into one of two independent 2-entry FIFOs, and presents each FIFO on its own valid/ready output. It sits between a single producer (e.g. ALU/result bus) and two consumers (e.g. register-file write port and memory store path), decoupling their stalls.

## Interface
- WIDTH, 16, data word width
- CNT_W, 8, width of per-port delivery counters
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  input word
- in_sel  in  1  destination: 0 -> port A, 1 -> port B
- in_valid  in  1  producer has a word
- in_ready  out  1  selected port's FIFO not full
- out_a_data  out  WIDTH  head of FIFO A
- out_a_valid  out  1  FIFO A non-empty
- out_a_ready  in  1  consumer A takes the word
- out_b_data, out_b_valid, out_b_ready: as port A, for FIFO B
- cnt_a  out  CNT_W  completed port-A output handshakes, wrapping
- cnt_b  out  CNT_W  completed port-B output handshakes, wrapping
- busy  out  1  either FIFO non-empty

## Operation
- Input accept: in_valid & in_ready at a rising edge writes in_data into the FIFO chosen by in_sel. The other FIFO is untouched.
- in_ready = ~full of FIFO[in_sel]. It is combinational on in_sel and FIFO state only and never depends on out_x_ready.
- in_ready may be high while in_valid is low. The producer must hold in_data/in_sel stable while in_valid & ~in_ready.
- Each FIFO has 2 entries, 1-bit read/write pointers and a 2-bit occupancy count (0..2). Full = count 2; empty = count 0.
- Output: out_x_valid = count_x != 0. out_x_data = entry at the read pointer. A pop occurs on out_x_valid & out_x_ready.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
- Push on a full FIFO cannot occur, because in_ready is low. A pop that same cycle does not enable a push; in_ready rises the following cycle.
- Pop on an empty FIFO is ignored. out_x_ready is a don't-care while out_x_valid is low.
- Per-port order is FIFO. There is no ordering relation between ports A and B.
- Head-of-line: a stalled word destined for a full port blocks all later input, including words for the other port.
- cnt_x increments by 1 on each port-x pop and wraps from 2^CNT_W-1 to 0.
- busy = (count_a != 0) | (count_b != 0).

## Timing
- Reset (async assert, sync-release handled upstream): both FIFOs empty, pointers 0, storage cleared to 0, cnt_a = cnt_b = 0.
- Output values during reset: out_a_valid = out_b_valid = 0, out_a_data = out_b_data = 0, busy = 0, in_ready = 1.
- Reset mid-operation: all buffered words are discarded immediately. Counters return to 0.
- Latency: a word accepted at edge k is visible on out_x_data/out_x_valid after edge k (next cycle). There is no combinational input-to-output path.
- Throughput: 1 word/cycle sustained per port when the consumer holds ready high. Alternating in_sel also sustains 1 word/cycle.
- in_ready after a pop from a full FIFO rises one cycle after the pop edge.
- Counters update at the pop edge and are visible the next cycle.

## Test plan
- Reset: assert rst mid-stream with A holding 2 words -> out_a_valid = 0, cnt_a = 0, busy = 0, in_ready = 1 immediately, without waiting for a clock edge.
- Basic routing: send 0x1111 (sel 0) and 0x2222 (sel 1) with both readies high -> out_a_data = 0x1111 and out_b_data = 0x2222 each valid one cycle after their accepts; cnt_a = cnt_b = 1.
- Fill/backpressure: out_a_ready = 0, send 0xA001, 0xA002, 0xA003 to A -> in_ready drops after the 2nd accept. Raise out_a_ready -> pops 0xA001 then 0xA002 in order; 0xA003 is accepted the cycle after the first pop.
- Head-of-line: A full and stalled, then present 0xB00B with sel 1 -> in_ready = 1 and it is accepted into B. Present a word with sel 0 -> in_ready = 0 and it stays held.
- Simultaneous push/pop: A holds 1 word, push 0x5555 to A while popping -> count stays 1, next head = 0x5555.
- Counter wrap: 256 pops on B with CNT_W = 8 -> cnt_b returns to 0x00. The 257th pop gives 0x01.

Source files
------------

// File: rtl/demux_buf_if.sv
// demux_buf_if: producer-side and consumer-side signals of the buffered 1-to-2 demux.
interface demux_buf_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_a_data;
    logic             out_a_valid;
    logic             out_a_ready;
    logic [WIDTH-1:0] out_b_data;
    logic             out_b_valid;
    logic             out_b_ready;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             busy;

    modport master (
        output in_data, in_sel, in_valid, out_a_ready, out_b_ready,
        input  in_ready, out_a_data, out_a_valid, out_b_data, out_b_valid, cnt_a, cnt_b, busy
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_a_ready, out_b_ready,
        output in_ready, out_a_data, out_a_valid, out_b_data, out_b_valid, cnt_a, cnt_b, busy
    );
endinterface

// File: rtl/demux_buf.sv
// demux_buf: steers each input word by in_sel into one of two 2-entry FIFOs,
// each drained through its own valid/ready port with a wrapping pop counter.
module demux_buf #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input logic         clk,
    input logic         rst,
    demux_buf_if.slave  bus
);
    logic [WIDTH-1:0] mem_q [2][2];
    logic [WIDTH-1:0] mem_d [2][2];
    logic [1:0]       occ_q [2];
    logic [1:0]       occ_d [2];
    logic [CNT_W-1:0] dcnt_q [2];
    logic [CNT_W-1:0] dcnt_d [2];
    logic [1:0]       wp_q, wp_d, rp_q, rp_d;
    logic [1:0]       push, pop, full, out_rdy;

    // index 0 is port A, index 1 is port B
    always_comb begin
        out_rdy = {bus.out_b_ready, bus.out_a_ready};
        for (int p = 0; p < 2; p++) begin
            full[p]   = occ_q[p] == 2'd2;
            push[p]   = bus.in_valid && !full[p] && (bus.in_sel == 1'(p));
            pop[p]    = (occ_q[p] != 2'd0) && out_rdy[p];
            mem_d[p]  = mem_q[p];
            if (push[p]) mem_d[p][wp_q[p]] = bus.in_data;
            wp_d[p]   = wp_q[p] ^ push[p];
            rp_d[p]   = rp_q[p] ^ pop[p];
            occ_d[p]  = occ_q[p] + 2'(push[p]) - 2'(pop[p]);
            dcnt_d[p] = dcnt_q[p] + CNT_W'(pop[p]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                mem_q[p]  <= '{default: '0};
                occ_q[p]  <= '0;
                dcnt_q[p] <= '0;
            end
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            mem_q  <= mem_d;
            occ_q  <= occ_d;
            dcnt_q <= dcnt_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
        end
    end

    // in_ready looks only at the selected FIFO's fill, never at consumer ready
    assign bus.in_ready    = !full[bus.in_sel];
    assign bus.out_a_valid = occ_q[0] != 2'd0;
    assign bus.out_b_valid = occ_q[1] != 2'd0;
    assign bus.out_a_data  = mem_q[0][rp_q[0]];
    assign bus.out_b_data  = mem_q[1][rp_q[1]];
    assign bus.cnt_a       = dcnt_q[0];
    assign bus.cnt_b       = dcnt_q[1];
    assign bus.busy        = bus.out_a_valid || bus.out_b_valid;
endmodule

// File: tb/tb_demux_buf.sv
// tb_demux_buf: directed and random stimulus against a queue-based model of the demux.
module tb_demux_buf;
    logic clk = 0;
    logic rst = 1;
    int   n_cmp = 0;
    int   n_err = 0;

    demux_buf_if #(.WIDTH(16), .CNT_W(8)) bus ();
    demux_buf #(.WIDTH(16), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [7:0]  mca = 0;
    logic [7:0]  mcb = 0;
    bit          pa, pb, pu;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: a push needs room before this edge's pop, per-port FIFO queues
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            mca = 0;
            mcb = 0;
        end else begin
            pa = qa.size() != 0 && bus.out_a_ready;
            pb = qb.size() != 0 && bus.out_b_ready;
            pu = bus.in_valid && ((bus.in_sel ? qb.size() : qa.size()) < 2);
            if (pa) begin void'(qa.pop_front()); mca++; end
            if (pb) begin void'(qb.pop_front()); mcb++; end
            if (pu) begin
                if (bus.in_sel) qb.push_back(bus.in_data);
                else qa.push_back(bus.in_data);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready), 32'(((bus.in_sel ? qb.size() : qa.size()) < 2)));
        chk("a_valid", 32'(bus.out_a_valid), 32'(qa.size() != 0));
        chk("b_valid", 32'(bus.out_b_valid), 32'(qb.size() != 0));
        if (qa.size() != 0) chk("a_data", 32'(bus.out_a_data), 32'(qa[0]));
        if (qb.size() != 0) chk("b_data", 32'(bus.out_b_data), 32'(qb[0]));
        chk("cnt_a", 32'(bus.cnt_a), 32'(mca));
        chk("cnt_b", 32'(bus.cnt_b), 32'(mcb));
        chk("busy", 32'(bus.busy), 32'(qa.size() != 0 || qb.size() != 0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present a word and hold it until an edge accepts it
    task automatic send(input logic [15:0] d, input logic s);
        bit acc;
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_valid = 1;
        acc = 0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
        end
        if (!acc) chk("send_timeout", 0, 1);
        bus.in_valid = 0;
    endtask

    initial begin
        bit acc;
        bus.in_data = 0; bus.in_sel = 0; bus.in_valid = 0;
        bus.out_a_ready = 1; bus.out_b_ready = 1;
        #1;
        chk("rst_a_valid", 32'(bus.out_a_valid), 0);
        chk("rst_a_data", 32'(bus.out_a_data), 0);
        chk("rst_b_data", 32'(bus.out_b_data), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        step(); step();
        rst = 0;
        step();

        send(16'h1111, 0);
        chk("route_a_valid", 32'(bus.out_a_valid), 1);
        chk("route_a_data", 32'(bus.out_a_data), 32'h1111);
        send(16'h2222, 1);
        chk("route_b_valid", 32'(bus.out_b_valid), 1);
        chk("route_b_data", 32'(bus.out_b_data), 32'h2222);
        step();
        chk("route_cnt_a", 32'(bus.cnt_a), 1);
        chk("route_cnt_b", 32'(bus.cnt_b), 1);
        chk("route_busy", 32'(bus.busy), 0);

        bus.out_a_ready = 0;
        send(16'hA001, 0);
        send(16'hA002, 0);
        chk("fill_in_ready", 32'(bus.in_ready), 0);
        bus.in_data = 16'hA003; bus.in_sel = 0; bus.in_valid = 1;
        bus.out_a_ready = 1;
        @(negedge clk);
        chk("fill_head1", 32'(bus.out_a_data), 32'hA001);
        chk("fill_blocked", 32'(bus.in_ready), 0);
        step();
        @(negedge clk);
        chk("fill_head2", 32'(bus.out_a_data), 32'hA002);
        chk("fill_reopen", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 0;
        @(negedge clk);
        chk("fill_head3", 32'(bus.out_a_data), 32'hA003);
        step(); step();

        bus.out_a_ready = 0; bus.out_b_ready = 0;
        send(16'hC001, 0);
        send(16'hC002, 0);
        bus.in_data = 16'hB00B; bus.in_sel = 1; bus.in_valid = 1;
        @(negedge clk);
        chk("hol_b_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 0;
        chk("hol_b_data", 32'(bus.out_b_data), 32'hB00B);
        bus.in_data = 16'hC003; bus.in_sel = 0; bus.in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hol_a_held", 32'(bus.in_ready), 0);
            chk("hol_a_head", 32'(bus.out_a_data), 32'hC001);
            step();
        end
        bus.out_a_ready = 1; bus.out_b_ready = 1;
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
        end
        bus.in_valid = 0;
        repeat (4) step();

        bus.out_a_ready = 0;
        send(16'h4444, 0);
        bus.in_data = 16'h5555; bus.in_sel = 0; bus.in_valid = 1;
        bus.out_a_ready = 1;
        step();
        bus.in_valid = 0; bus.out_a_ready = 0;
        chk("pp_valid", 32'(bus.out_a_valid), 1);
        chk("pp_head", 32'(bus.out_a_data), 32'h5555);
        chk("pp_not_full", 32'(bus.in_ready), 1);
        bus.out_a_ready = 1;
        step();
        chk("pp_drained", 32'(bus.out_a_valid), 0);

        bus.out_a_ready = 0;
        send(16'hD001, 0);
        send(16'hD002, 0);
        #3 rst = 1;
        #1;
        chk("arst_a_valid", 32'(bus.out_a_valid), 0);
        chk("arst_cnt_a", 32'(bus.cnt_a), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_in_ready", 32'(bus.in_ready), 1);
        step();
        rst = 0;
        bus.out_a_ready = 1;

        for (int i = 0; i < 256; i++) begin
            send(16'($urandom), 1);
            if (i == 254) chk("wrap_255", 32'(bus.cnt_b), 254);
        end
        step();
        chk("wrap_256", 32'(bus.cnt_b), 0);
        send(16'h0257, 1);
        step();
        chk("wrap_257", 32'(bus.cnt_b), 1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            if (c % 700 == 699) begin
                #2 rst = 1;
                step();
                rst = 0;
            end
            if (!(bus.in_valid && !acc)) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 1'($urandom);
                bus.in_data  = 16'($urandom);
            end
            bus.out_a_ready = ($urandom_range(0, 2) != 0);
            bus.out_b_ready = ($urandom_range(0, 3) == 0);
        end
        bus.in_valid = 0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
